// File: rtl/mem_bus_responder.sv
// Memory-bus target: buffers requests in a small FIFO, services them one at a
// time after a fixed access latency and returns in-order valid/ready responses.
module mem_bus_responder #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_write,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    input  logic [DATA_WIDTH-1:0]            req_wdata,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic                             rsp_write,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_error,
    output logic [$clog2(QUEUE_DEPTH+2)-1:0] outstanding
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam int OUT_W = $clog2(QUEUE_DEPTH + 2);
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] WAIT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // Request FIFO
    req_t             fifo_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic             pop;
    req_t             push_entry;
    req_t             head;

    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == CNT_W'(QUEUE_DEPTH));
    assign req_ready  = !fifo_full;
    assign push       = req_valid && req_ready;
    assign push_entry = '{write: req_write, addr: req_addr, wdata: req_wdata};
    assign head       = fifo_mem[rd_ptr_reg];

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= push_entry;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Service FSM
    state_t     state_reg;
    state_t     state_next;
    logic [3:0] cnt_reg;
    logic [3:0] cnt_next;
    logic       load_svc;
    logic       enter_resp;
    req_t       svc_reg;
    req_t       acc;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        pop        = 1'b0;
        load_svc   = 1'b0;
        enter_resp = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                end
            end
            WAIT: begin
                if (cnt_reg == 4'd0) begin
                    state_next = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        // A popped head either goes straight to the access or waits out the latency
        if (pop) begin
            if (LATENCY == 1) begin
                state_next = RESP;
                enter_resp = 1'b1;
            end else begin
                state_next = WAIT;
                cnt_next   = WAIT_LOAD;
                load_svc   = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_ff @(posedge clock) begin
        if (load_svc) begin
            svc_reg <= head;
        end
    end

    // The access uses the latched request after a wait, else the head being popped
    assign acc = (state_reg == WAIT) ? svc_reg : head;

    // Memory array, cleared by reset
    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
    logic                  in_range;
    logic [IDX_W-1:0]      mem_idx;
    logic                  mem_we;

    assign in_range = (acc.addr < ADDR_WIDTH'(DEPTH_WORDS));
    assign mem_idx  = acc.addr[IDX_W-1:0];
    assign mem_we   = enter_resp && acc.write && in_range;

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (mem_we) begin
            mem[mem_idx] <= acc.wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
        end else if (enter_resp) begin
            rsp_write <= acc.write;
            rsp_error <= !in_range;
            if (!in_range) begin
                rsp_rdata <= '0;
            end else if (acc.write) begin
                rsp_rdata <= acc.wdata;
            end else begin
                rsp_rdata <= mem[mem_idx];
            end
        end
    end

    assign rsp_valid   = (state_reg == RESP);
    assign outstanding = OUT_W'(count_reg) + OUT_W'(state_reg != IDLE);

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: one LATENCY=2 instance for the bulk of
// the checks and one LATENCY=1 instance for streaming throughput.
module tb_mem_bus_responder;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int OW = 3;

    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic reset;

    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_ready, rsp_write, rsp_error;
    logic [DW-1:0] rsp_rdata;
    logic [OW-1:0] outstanding;

    logic          req_valid_l1, req_ready_l1, req_write_l1;
    logic [AW-1:0] req_addr_l1;
    logic [DW-1:0] req_wdata_l1;
    logic          rsp_valid_l1, rsp_ready_l1, rsp_write_l1, rsp_error_l1;
    logic [DW-1:0] rsp_rdata_l1;
    logic [OW-1:0] outstanding_l1;

    mem_bus_responder #(.LATENCY(2)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_error(rsp_error), .outstanding(outstanding)
    );

    mem_bus_responder #(.LATENCY(1)) dut_l1 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid_l1), .req_ready(req_ready_l1), .req_write(req_write_l1),
        .req_addr(req_addr_l1), .req_wdata(req_wdata_l1),
        .rsp_valid(rsp_valid_l1), .rsp_ready(rsp_ready_l1), .rsp_write(rsp_write_l1),
        .rsp_rdata(rsp_rdata_l1), .rsp_error(rsp_error_l1), .outstanding(outstanding_l1)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_d [8];
    logic        exp_w [8];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Collect n responses from the LATENCY=2 instance (rsp_ready must be 1)
    task automatic drain(input int n, input string tag);
        int got = 0;
        for (int c = 0; c < 60 && got < n; c++) begin
            if (rsp_valid) begin
                chk($sformatf("%s_data%0d", tag, got), rsp_rdata, exp_d[got]);
                chk($sformatf("%s_write%0d", tag, got), 32'(rsp_write), 32'(exp_w[got]));
                got++;
            end
            tick();
        end
        chk({tag, "_count"}, got, n);
    endtask

    // Issue one request to the LATENCY=2 instance and check its response
    task automatic do_req(input string tag, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_data, input logic exp_err);
        int c;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        c = 0;
        while (!req_ready && c < 20) begin
            tick();
            c++;
        end
        tick();
        req_valid = 1'b0;
        c = 0;
        while (!rsp_valid && c < 40) begin
            tick();
            c++;
        end
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_data"}, rsp_rdata, exp_data);
        chk({tag, "_error"}, 32'(rsp_error), 32'(exp_err));
        chk({tag, "_write"}, 32'(rsp_write), 32'(w));
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, ri, got, gaps;
        bit started, acc;

        reset = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
        req_valid_l1 = 1'b0; req_write_l1 = 1'b0; req_addr_l1 = '0; req_wdata_l1 = '0;
        rsp_ready_l1 = 1'b1;
        tick();
        tick();
        reset = 1'b1;

        // Reset state
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_write", 32'(rsp_write), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_error", 32'(rsp_error), 32'd0);
        chk("rst_outstanding", 32'(outstanding), 32'd0);

        // Write then read with exact LATENCY=2 timing
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'd5; req_wdata = 32'hDEADBEEF;
        tick();
        req_valid = 1'b0;
        chk("wr_k0_valid", 32'(rsp_valid), 32'd0);
        chk("wr_k0_outstanding", 32'(outstanding), 32'd1);
        tick();
        chk("wr_k1_valid", 32'(rsp_valid), 32'd0);
        tick();
        chk("wr_k2_valid", 32'(rsp_valid), 32'd1);
        chk("wr_k2_write", 32'(rsp_write), 32'd1);
        chk("wr_k2_data", rsp_rdata, 32'hDEADBEEF);
        chk("wr_k2_error", 32'(rsp_error), 32'd0);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'd5; req_wdata = 32'h0;
        tick();
        req_valid = 1'b0;
        chk("rd_k0_valid", 32'(rsp_valid), 32'd0);
        chk("rd_k0_outstanding", 32'(outstanding), 32'd1);
        tick();
        tick();
        chk("rd_k2_valid", 32'(rsp_valid), 32'd1);
        chk("rd_k2_data", rsp_rdata, 32'hDEADBEEF);
        chk("rd_k2_write", 32'(rsp_write), 32'd0);
        chk("rd_k2_error", 32'(rsp_error), 32'd0);
        tick();
        chk("rd_done_outstanding", 32'(outstanding), 32'd0);

        // Backpressure: response held stable while rsp_ready is low
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'd5;
        tick();
        req_valid = 1'b0;
        c = 0;
        while (!rsp_valid && c < 20) begin
            tick();
            c++;
        end
        chk("bp_valid", 32'(rsp_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("bp_hold%0d_valid", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp_hold%0d_data", i), rsp_rdata, 32'hDEADBEEF);
            chk($sformatf("bp_hold%0d_error", i), 32'(rsp_error), 32'd0);
            chk($sformatf("bp_hold%0d_outstanding", i), 32'(outstanding), 32'd1);
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_release_valid", 32'(rsp_valid), 32'd0);
        chk("bp_release_outstanding", 32'(outstanding), 32'd0);

        // Full: five accepted with responses stalled, sixth waits
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_write = 1'b1; req_addr = 32'(10 + i); req_wdata = 32'(32'h100 + i);
            tick();
        end
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'd12; req_wdata = 32'h0;
        chk("full_req_ready", 32'(req_ready), 32'd0);
        chk("full_outstanding", 32'(outstanding), 32'd5);
        tick();
        chk("full_hold_req_ready", 32'(req_ready), 32'd0);
        chk("full_hold_outstanding", 32'(outstanding), 32'd5);
        chk("full_first_valid", 32'(rsp_valid), 32'd1);
        chk("full_first_data", rsp_rdata, 32'h100);
        rsp_ready = 1'b1;
        tick();
        chk("full_pop_req_ready", 32'(req_ready), 32'd1);
        chk("full_pop_outstanding", 32'(outstanding), 32'd4);
        tick();
        req_valid = 1'b0;
        chk("full_sixth_outstanding", 32'(outstanding), 32'd5);
        exp_d[0] = 32'h101; exp_w[0] = 1'b1;
        exp_d[1] = 32'h102; exp_w[1] = 1'b1;
        exp_d[2] = 32'h103; exp_w[2] = 1'b1;
        exp_d[3] = 32'h104; exp_w[3] = 1'b1;
        exp_d[4] = 32'h102; exp_w[4] = 1'b0;
        drain(5, "full_rsp");
        chk("full_end_outstanding", 32'(outstanding), 32'd0);

        // Out-of-range accesses leave memory untouched
        do_req("oor_wr300", 1'b1, 32'd300, 32'h1234, 32'h0, 1'b1);
        do_req("oor_rd256", 1'b0, 32'd256, 32'h0, 32'h0, 1'b1);
        do_req("oor_rd44", 1'b0, 32'd44, 32'h0, 32'h0, 1'b0);

        // Reset mid-traffic
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'd6; req_wdata = 32'h77;
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        req_valid = 1'b0;
        chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_outstanding", 32'(outstanding), 32'd0);
        rsp_ready = 1'b1;
        do_req("mid_rst_rd5", 1'b0, 32'd5, 32'h0, 32'h0, 1'b0);
        do_req("mid_rst_rd12", 1'b0, 32'd12, 32'h0, 32'h0, 1'b0);

        // LATENCY=1: preload addrs 0..7, then stream 8 reads
        for (int i = 0; i < 8; i++) begin
            req_valid_l1 = 1'b1; req_write_l1 = 1'b1;
            req_addr_l1 = 32'(i); req_wdata_l1 = 32'(32'h10 + i);
            c = 0;
            while (!req_ready_l1 && c < 20) begin
                tick();
                c++;
            end
            tick();
        end
        req_valid_l1 = 1'b0;
        c = 0;
        while (outstanding_l1 != '0 && c < 40) begin
            tick();
            c++;
        end
        chk("l1_preload_outstanding", 32'(outstanding_l1), 32'd0);

        ri = 0; got = 0; gaps = 0; started = 1'b0;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            if (rsp_valid_l1) begin
                chk($sformatf("l1_stream_data%0d", got), rsp_rdata_l1, 32'(32'h10 + got));
                got++;
                started = 1'b1;
            end else if (started) begin
                gaps++;
            end
            if (ri < 8) begin
                req_valid_l1 = 1'b1; req_write_l1 = 1'b0; req_addr_l1 = 32'(ri);
            end else begin
                req_valid_l1 = 1'b0;
            end
            acc = req_valid_l1 && req_ready_l1;
            tick();
            if (acc) begin
                ri++;
            end
        end
        req_valid_l1 = 1'b0;
        chk("l1_stream_count", got, 32'd8);
        chk("l1_stream_gaps", gaps, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_bus_responder.md
# mem_bus_responder

Single-port memory responder for the core memory bus: the target end that accepts read/write requests from a bus initiator (the CPU core side) and returns in-order responses after a fixed, parameterized access latency. Accepted requests are buffered in a small FIFO, serviced one at a time by a latency FSM, and answered over a valid/ready response channel with backpressure. It serves as a latency-modelling data memory in CPU benches and as a drop-in target behind the memory bus.

## Interface
- ADDR_WIDTH, 32, request address width (word addressed).
- DATA_WIDTH, 32, data word width.
- DEPTH_WORDS, 256, memory size in words; index = req_addr when req_addr < DEPTH_WORDS.
- LATENCY, 2, edges from request acceptance to rsp_valid with an idle responder; legal range 1..15.
- QUEUE_DEPTH, 4, request FIFO entries; power of two, ≥2.

- clock  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-low: sampled low at a rising edge resets the block.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; equals !fifo_full, registered-state only, no combinational path from any input.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  initiator accepts response.
- rsp_write  out  1  echo of serviced request's req_write.
- rsp_rdata  out  DATA_WIDTH  read: memory word; write: data written; error: 0.
- rsp_error  out  1  address ≥ DEPTH_WORDS.
- outstanding  out  $clog2(QUEUE_DEPTH+2)  FIFO count + (FSM != IDLE).

## Operation
- Accept: req_valid & req_ready at an edge pushes {write, addr, wdata} into FIFO.
- FSM states IDLE, WAIT, RESP; down-counter cnt (4 bits).
- IDLE: if FIFO non-empty, pop head into service register; LATENCY==1 → RESP, else WAIT with cnt=LATENCY-2.
- WAIT: cnt==0 → RESP, else cnt-1.
- Entering RESP: memory access performed on that edge. In-range write updates mem[addr]; rsp_rdata = wdata. In-range read: rsp_rdata = mem[addr] (reflects all earlier writes). Out-of-range: rsp_error=1, rsp_rdata=0, memory unchanged.
- RESP: rsp_valid=1; rsp_* held stable until rsp_valid & rsp_ready. On handshake: FIFO non-empty → pop next (→RESP if LATENCY==1, else WAIT); empty → IDLE.
- Strict in-order service; one request in service at a time.
- Full FIFO: req_ready=0 even if a pop occurs the same edge; push+pop same edge on non-full FIFO keeps count.
- Memory contents cleared to 0 by reset; counter and FIFO pointers wrap modulo QUEUE_DEPTH.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_write=0, rsp_rdata=0, rsp_error=0, outstanding=0; FSM IDLE; FIFO empty; memory all 0.
- Reset mid-operation: all queued and in-service requests dropped, no response emitted, memory cleared; takes priority over any simultaneous handshake.
- Idle latency: request accepted at edge k → rsp_valid high after edge k+LATENCY.
- Back-to-back with rsp_ready=1: responses spaced LATENCY cycles apart; LATENCY=1 gives one response per cycle.
- Stalled responses: capacity QUEUE_DEPTH+1 requests (QUEUE_DEPTH queued + 1 in service).
- outstanding updates on the same edge as push/pop/handshake.

## Test plan
- Reset: hold reset=0 for 2 edges mid-traffic → req_ready=1, rsp_valid=0, outstanding=0; read addr 5 afterwards returns 0.
- Write/read, LATENCY=2: write 0xDEADBEEF to addr 5 at edge k → rsp_valid after k+2, rsp_write=1, rdata 0xDEADBEEF; read addr 5 next → rdata 0xDEADBEEF, rsp_error=0.
- Full: rsp_ready=0, issue 6 requests back-to-back (QUEUE_DEPTH=4) → 5 accepted, req_ready=0, outstanding=5; raise rsp_ready → 6th accepted, all 6 responses in issue order.
- Out-of-range: write 0x1234 to addr 300, read addr 256 → both rsp_error=1, rdata 0; mem[300 mod 256]=mem[44] still 0.
- Backpressure: hold rsp_ready=0 for 3 cycles during a read response → rsp_valid, rsp_rdata, rsp_error stable, outstanding unchanged until handshake.
- LATENCY=1 streaming: 8 reads of addrs 0..7 preloaded with 0x10..0x17, rsp_ready=1 → 8 consecutive cycles of rsp_valid with rdata 0x10..0x17.
